// File: rtl/comm_uart_tx.sv
// UART transmit back-end: a small FIFO absorbs packets from the channel multiplexer and
// a serializer shifts each one out as start bit, PACKET_SIZE data bits LSB first, stop bit.
module comm_uart_tx #(
  parameter int PACKET_SIZE    = 8,
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int FIFO_DEPTH_BIT = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   send_flag,
  input  logic [PACKET_SIZE-1:0] send_data,
  output logic                   sendable,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   overflow
);

  localparam int DIV    = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH  = 1 << FIFO_DEPTH_BIT;
  localparam int BAUD_W = $clog2(DIV);
  localparam int BIT_W  = $clog2(PACKET_SIZE);
  localparam int CNT_W  = FIFO_DEPTH_BIT + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0]  FULL       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  SEND_LIMIT = CNT_W'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [PACKET_SIZE-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] wr_ptr;
  logic [FIFO_DEPTH_BIT-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [PACKET_SIZE-1:0]    shift;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      baud_tick;
  logic                      pop;
  logic                      push;
  logic                      tx_next;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign pop       = (state == IDLE) && (count != '0);
  // A pop on the same edge frees a slot, so a write to a full FIFO is still accepted then.
  assign push      = send_flag && ((count != FULL) || pop);
  assign sendable  = (count <= SEND_LIMIT);
  assign tx_busy   = (count != '0) || (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = START;
      START:   if (baud_tick) state_next = DATA;
      DATA:    if (baud_tick && (bit_cnt == BIT_LAST)) state_next = STOP;
      STOP:    if (baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= send_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (send_flag && !push) overflow <= 1'b1;
    end
  end

  // tx is registered from the state, so the line lags the FSM by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_next;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) shift <= mem[rd_ptr];
        end
        START: begin
          baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
          bit_cnt  <= '0;
        end
        DATA: begin
          baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
          if (baud_tick) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comm_uart_tx.sv
// Testbench for comm_uart_tx: accepted packets go into a scoreboard queue, and a UART line
// monitor decodes every frame from tx and compares it against the queue head.
module tb_comm_uart_tx;
  localparam int PS    = 8;
  localparam int DIV   = 4;
  localparam int FRAME = (PS + 2) * DIV;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          send_flag = 1'b0;
  logic [PS-1:0] send_data = '0;
  logic          sendable;
  logic          tx;
  logic          tx_busy;
  logic          overflow;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [PS-1:0] exp_q[$];
  int            starts[$];
  bit            in_frame = 1'b0;
  int            fcnt = 0;
  logic [PS+1:0] bits = '0;

  comm_uart_tx #(
    .PACKET_SIZE(PS), .CLK_FREQ(400), .BAUD_RATE(100), .FIFO_DEPTH_BIT(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .send_flag(send_flag), .send_data(send_data),
    .sendable(sendable), .tx(tx), .tx_busy(tx_busy), .overflow(overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Line monitor: samples each bit mid-way through its baud period.
  always @(negedge CLK) begin
    if (!RST_N) in_frame = 1'b0;
    else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1'b1;
        fcnt = 0;
        starts.push_back(cyc);
      end
    end else fcnt++;
    if (in_frame && RST_N && (fcnt % DIV == DIV / 2)) begin
      bits[fcnt / DIV] = tx;
      if (fcnt / DIV == PS + 1) begin
        in_frame = 1'b0;
        check_output("start_bit", {31'd0, bits[0]}, 32'd0);
        check_output("stop_bit", {31'd0, bits[PS+1]}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame_unexpected: got %0h, expected no frame", bits[PS:1]);
        end else check_output("frame_data", {24'd0, bits[PS:1]}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic apply_stimulus(input logic flag, input logic [PS-1:0] data);
    @(negedge CLK);
    send_flag = flag;
    send_data = data;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    send_flag = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    RST_N = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_busy || in_frame) && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    check_output({name, "_drain_timeout"}, {31'd0, n < 20000}, 32'd1);
    check_output({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  // Upstream that samples sendable and issues its write one edge later.
  task automatic pipelined_send(input int n_pkts, input int gap_pct, input string name);
    int sent = 0;
    int guard = 0;
    logic prev_s;
    logic [PS-1:0] d;
    prev_s = sendable;
    while (sent < n_pkts && guard < 60000) begin
      @(negedge CLK);
      guard++;
      if (prev_s && ($urandom_range(0, 99) >= gap_pct)) begin
        d = PS'($urandom);
        send_flag = 1'b1;
        send_data = d;
        exp_q.push_back(d);
        sent++;
      end else send_flag = 1'b0;
      prev_s = sendable;
    end
    check_output({name, "_send_timeout"}, {31'd0, guard < 60000}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PS-1:0] pkt;
    logic          flag;
    int            base;
    bit            all_high;

    // Reset state while RST_N is still low
    repeat (2) @(negedge CLK);
    check_output("reset_tx", {31'd0, tx}, 32'd1);
    check_output("reset_busy", {31'd0, tx_busy}, 32'd0);
    check_output("reset_sendable", {31'd0, sendable}, 32'd1);
    check_output("reset_overflow", {31'd0, overflow}, 32'd0);

    // Test 1: single 0xA5 frame, cycle-exact waveform
    do_reset();
    pkt = 8'hA5;
    apply_stimulus(1'b1, pkt);
    exp_q.push_back(pkt);
    apply_stimulus(1'b0, '0);
    check_output("t1_busy_after_write", {31'd0, tx_busy}, 32'd1);
    @(negedge CLK);
    check_output("t1_high_before_start", {31'd0, tx}, 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      if (i / DIV == 0)           check_output("t1_wave_start", {31'd0, tx}, 32'd0);
      else if (i / DIV <= PS)     check_output("t1_wave_data", {31'd0, tx}, {31'd0, pkt[i/DIV-1]});
      else                        check_output("t1_wave_stop", {31'd0, tx}, 32'd1);
    end
    @(negedge CLK);
    check_output("t1_idle_after", {31'd0, tx}, 32'd1);
    wait_idle("t1");

    // Test 2: burst of 4 honouring sendable; frames 41 cycles apart
    do_reset();
    base = starts.size();
    pipelined_send(4, 0, "t2");
    apply_stimulus(1'b0, '0);
    check_output("t2_sendable_low_at_3", {31'd0, sendable}, 32'd0);
    wait_idle("t2");
    check_output("t2_frame_count", starts.size() - base, 32'd4);
    if (starts.size() - base == 4)
      for (int i = 0; i < 3; i++)
        check_output("t2_spacing", starts[base+i+1] - starts[base+i], FRAME + 1);
    check_output("t2_overflow", {31'd0, overflow}, 32'd0);

    // Test 3: ignore sendable while a frame is in progress; 5th write dropped
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      flag = (c == 1) || (c >= 3 && c <= 7);
      pkt = PS'($urandom);
      apply_stimulus(flag, pkt);
      if (flag && c != 7) exp_q.push_back(pkt);
      if (c == 7) begin
        check_output("t3_overflow_before_drop", {31'd0, overflow}, 32'd0);
        check_output("t3_sendable_full", {31'd0, sendable}, 32'd0);
      end
    end
    check_output("t3_overflow_set", {31'd0, overflow}, 32'd1);
    wait_idle("t3");
    check_output("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    do_reset();
    check_output("t3_overflow_cleared", {31'd0, overflow}, 32'd0);

    // Test 4: write to a full FIFO on the edge the serializer pops (edge 43)
    do_reset();
    for (int c = 1; c <= 44; c++) begin
      flag = (c == 1) || (c >= 3 && c <= 6) || (c == 43);
      pkt = PS'($urandom);
      apply_stimulus(flag, pkt);
      if (flag) exp_q.push_back(pkt);
    end
    check_output("t4_overflow", {31'd0, overflow}, 32'd0);
    check_output("t4_still_full", {31'd0, sendable}, 32'd0);
    wait_idle("t4");
    check_output("t4_overflow_end", {31'd0, overflow}, 32'd0);

    // Test 5: reset in the middle of the data bits
    do_reset();
    apply_stimulus(1'b1, 8'h3C);
    exp_q.push_back(8'h3C);
    apply_stimulus(1'b0, '0);
    repeat (14) @(negedge CLK);
    check_output("t5_busy_mid_frame", {31'd0, tx_busy}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check_output("t5_tx_high", {31'd0, tx}, 32'd1);
    check_output("t5_busy_clear", {31'd0, tx_busy}, 32'd0);
    check_output("t5_sendable", {31'd0, sendable}, 32'd1);
    repeat (2) @(negedge CLK);
    exp_q.delete();
    RST_N = 1'b1;
    all_high = 1'b1;
    repeat (60) begin
      @(negedge CLK);
      if (tx !== 1'b1 || tx_busy !== 1'b0) all_high = 1'b0;
    end
    check_output("t5_idle_after_release", {31'd0, all_high}, 32'd1);

    // Test 6: 1000 random packets with random compliant gaps
    do_reset();
    pipelined_send(1000, 40, "t6");
    apply_stimulus(1'b0, '0);
    wait_idle("t6");
    check_output("t6_overflow", {31'd0, overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
